// File: rtl/mc_ctrl_sequencer.sv
// mc_ctrl_sequencer: central control FSM for the multi-cycle 8-bit register-file datapath
// Ports:
//   clk, rst (async, active-high)       clock and reset
//   start                               launches execution from IDLE
//   instr_valid / instr_ready, ir_load  instruction fetch handshake and IR load
//   ir_opcode, ir_func, ir_rt, ir_rd    fields of the loaded instruction register
//   dec_en, rf_read_en, alu_en, rf_we   per-stage enables
//   alu_op, alu_src_imm, rf_wsel        instruction class controls, registered in DECODE
//   result_latch, counter, done, trap   completion strobe, accepted-instruction count, status
// Macro INVALID_TRAP_EN: invalid instructions halt in TRAP instead of being skipped.
module mc_ctrl_sequencer #(
   parameter int MAX_PC = 10,
   parameter int CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             instr_valid,
   output logic             instr_ready,
   output logic             ir_load,
   input  logic [5:0]       ir_opcode,
   input  logic [5:0]       ir_func,
   input  logic [4:0]       ir_rt,
   input  logic [4:0]       ir_rd,
   output logic             dec_en,
   output logic             rf_read_en,
   output logic             alu_en,
   output logic             alu_op,
   output logic             alu_src_imm,
   output logic             rf_we,
   output logic             rf_wsel,
   output logic             result_latch,
   output logic [CNT_W-1:0] counter,
   output logic             done,
   output logic             trap
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, READ, EXEC, WB, DONE
`ifdef INVALID_TRAP_EN
      , TRAP
`endif
   } state_t;
   state_t state;
   logic invalid, dst_nz;
   logic is_r, is_add, is_sub, is_addi;
   assign is_r    = ir_opcode == 6'd0;
   assign is_add  = is_r && ir_func == 6'd33;
   assign is_sub  = is_r && ir_func == 6'd35;
   assign is_addi = ir_opcode == 6'd9;
   // instr_ready is a registered copy of (state == FETCH), so this is the Mealy accept
   assign ir_load = instr_ready & instr_valid;
`ifndef INVALID_TRAP_EN
   assign trap = 1'b0;
`endif
   // Stage enables are registered: each is set on the transition into its state
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state        <= IDLE;
         counter      <= '0;
         invalid      <= 1'b0;
         dst_nz       <= 1'b0;
         instr_ready  <= 1'b0;
         dec_en       <= 1'b0;
         rf_read_en   <= 1'b0;
         alu_en       <= 1'b0;
         alu_op       <= 1'b0;
         alu_src_imm  <= 1'b0;
         rf_we        <= 1'b0;
         rf_wsel      <= 1'b0;
         result_latch <= 1'b0;
         done         <= 1'b0;
`ifdef INVALID_TRAP_EN
         trap         <= 1'b0;
`endif
      end else begin
         result_latch <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state       <= FETCH;
               instr_ready <= 1'b1;
            end
            FETCH: if (instr_valid) begin
               state       <= DECODE;
               instr_ready <= 1'b0;
               dec_en      <= 1'b1;
               counter     <= counter + 1'b1;
            end
            DECODE: begin
               state       <= READ;
               dec_en      <= 1'b0;
               rf_read_en  <= 1'b1;
               invalid     <= ~(is_add | is_sub | is_addi);
               alu_op      <= is_sub;
               alu_src_imm <= is_addi;
               rf_wsel     <= is_addi;
               dst_nz      <= is_addi ? |ir_rt : |ir_rd;
            end
            READ: begin
               state      <= EXEC;
               rf_read_en <= 1'b0;
               alu_en     <= 1'b1;
            end
            EXEC: begin
               state  <= WB;
               alu_en <= 1'b0;
               rf_we  <= ~invalid & dst_nz;
            end
            WB: begin
               rf_we   <= 1'b0;
               invalid <= 1'b0;
`ifdef INVALID_TRAP_EN
               if (invalid) begin
                  state        <= TRAP;
                  trap         <= 1'b1;
                  done         <= 1'b1;
                  result_latch <= 1'b1;
               end else
`endif
               if (counter == CNT_W'(MAX_PC)) begin
                  state        <= DONE;
                  done         <= 1'b1;
                  result_latch <= 1'b1;
               end else begin
                  state       <= FETCH;
                  instr_ready <= 1'b1;
               end
            end
            default: ;
         endcase
      end
endmodule

// File: doc/mc_ctrl_sequencer.md
Name: mc_ctrl_sequencer

Overview:
- Central control FSM for the multi-cycle 8-bit register-file processor datapath.
- Accepts instructions from an instruction source over a valid/ready handshake and classifies the held instruction.
- Issues per-stage enables (load, decode, read, execute, writeback) to the datapath and counts executed instructions.
- Halts after MAX_PC instructions and signals result capture.

Parameters:
- MAX_PC, 10, number of instructions to execute before halting; range 1..2^CNT_W-1.
- CNT_W, 4, width of the instruction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins execution from IDLE; ignored in all other states.
- instr_valid  input  1  instruction source has an instruction on its bus.
- instr_ready  output  1  controller can accept an instruction.
- ir_load  output  1  datapath loads its instruction register this cycle.
- ir_opcode  input  6  opcode field, bits 31:26 of the loaded instruction register.
- ir_func  input  6  func field, bits 5:0.
- ir_rt  input  5  rt field, bits 20:16.
- ir_rd  input  5  rd field, bits 15:11.
- dec_en  output  1  decode-stage enable.
- rf_read_en  output  1  register-file operand read enable.
- alu_en  output  1  ALU result register enable.
- alu_op  output  1  0 = add, 1 = subtract.
- alu_src_imm  output  1  1 = second operand is the immediate.
- rf_we  output  1  register-file write enable.
- rf_wsel  output  1  write-address select: 0 = rd, 1 = rt.
- result_latch  output  1  one-cycle strobe to capture the output register.
- counter  output  CNT_W  number of accepted instructions.
- done  output  1  execution finished.
- trap  output  1  invalid-instruction trap; see Optional Feature.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-instruction):
  - state = IDLE; counter = 0; invalid flag = 0; done = trap = 0.
  - All enables and strobes are 0, including instr_ready and ir_load.
  - Any in-flight handshake is dropped.
- Output types:
  - All enables, done and trap are Moore outputs decoded from the registered state.
  - ir_load = (state == FETCH) & instr_valid, which is Mealy.
  - alu_op, alu_src_imm and rf_wsel come from the class registered in DECODE.
- IDLE: everything is 0. start -> FETCH.
- FETCH:
  - instr_ready = 1.
  - On instr_valid: ir_load = 1, counter increments, next state DECODE.
  - Without instr_valid: stay in FETCH (stall), counter unchanged.
- DECODE: dec_en = 1. Register the instruction class:
  - ADD: opcode 0, func 33 -> alu_op 0, alu_src_imm 0, rf_wsel 0.
  - SUB: opcode 0, func 35 -> alu_op 1, alu_src_imm 0, rf_wsel 0.
  - ADDI: opcode 9 -> alu_op 0, alu_src_imm 1, rf_wsel 1.
  - Anything else: invalid = 1, alu_op 0.
  - Next state READ.
- READ: rf_read_en = 1 -> EXEC.
- EXEC: alu_en = 1 -> WB.
- WB:
  - rf_we = 1 only when the instruction is valid AND the selected destination (rd for R-type, rt for ADDI) is nonzero; register 0 is never written.
  - invalid is cleared on exit from WB.
  - If counter == MAX_PC -> DONE; otherwise -> FETCH.
- DONE:
  - done = 1 held until rst.
  - result_latch = 1 only in the first DONE cycle.
  - counter holds; start and instr_valid are ignored.
- Latency: 5 cycles per instruction (FETCH accept through WB) with no stalls; done rises 1 cycle after the final WB.
- counter never wraps: it stops at MAX_PC.

Optional Feature:
- Macro: INVALID_TRAP_EN.
- Defined: an invalid instruction still passes WB with rf_we = 0, then enters TRAP instead of FETCH. In TRAP: trap = 1, done = 1, a one-cycle result_latch, held until rst.
- Undefined: an invalid instruction is silently skipped and still counts toward MAX_PC. trap is tied to 0 and the TRAP state does not exist.

Test Plan:
1. MAX_PC=1; rst, start, instr_valid high with opcode 0, func 33, rd 3 -> ir_load for 1 cycle; dec_en, rf_read_en, alu_en, rf_we each high for 1 consecutive cycle; rf_wsel=0, alu_op=0 in WB; done and result_latch rise the next cycle; counter=1.
2. ADDI, opcode 9, rt 0 -> alu_src_imm=1, rf_wsel=1, rf_we stays 0 throughout WB.
3. SUB, opcode 0, func 35, rd 5, with instr_valid held low 3 cycles in FETCH -> instr_ready high for 4 cycles, counter unchanged until accept, alu_op=1 in EXEC/WB.
4. MAX_PC=3, instructions back-to-back -> exactly 3 ir_load pulses 5 cycles apart; done 1 cycle after third WB; exactly one result_latch pulse; counter=3 and holds for 20 further cycles.
5. Invalid opcode 0, func 32 -> rf_we=0. With INVALID_TRAP_EN: trap=1, done=1, counter=1. Without it: next FETCH, trap=0.
6. rst asserted in EXEC -> alu_en, done and counter drop to 0 immediately (before the next edge); after release the controller stays in IDLE until start.
